z80_bus_responder: RTL and testbench
====================================

# z80_bus_responder

Target-side responder for the Z80 CPU bus. It decodes bus cycles driven by the CPU core (active-low mreq, iorq, rd, wr, m1, rfsh) and converts each qualifying memory or I/O cycle into exactly one request on a variable-latency request/acknowledge memory port. It returns read data to the CPU on its data input and drives wait_n to stretch the cycle until the memory port acknowledges. It sits between the CPU wrapper and the system RAM/ROM/IO fabric.

## Interface
Parameters:
- none.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mreq  in  1  CPU memory request, active low.
- iorq  in  1  CPU I/O request, active low.
- rd  in  1  CPU read strobe, active low.
- wr  in  1  CPU write strobe, active low.
- m1  in  1  CPU opcode-fetch / interrupt-acknowledge marker, active low.
- rfsh  in  1  CPU refresh marker, active low.
- a  in  16  CPU address.
- d  in  8  CPU write data (CPU data output).
- q  out  8  read data to CPU (CPU data input).
- wait_n  out  1  wait request to CPU, active low.
- mem_req  out  1  request level, held until acknowledged.
- mem_we  out  1  1 = write, 0 = read.
- mem_io  out  1  1 = I/O space, 0 = memory space.
- mem_addr  out  16  latched address.
- mem_wdata  out  8  latched write data.
- mem_rdata  in  8  read data, valid while mem_ack = 1.
- mem_ack  in  1  single-clock acknowledge.

## Operation
- Combinational qualifier: active = (~mreq & rfsh & (~rd | ~wr)) | (io_ok & ~iorq & m1 & (~rd | ~wr)). io_ok = 1 only with the configuration macro defined.
- The block registers active as active_prev every clock. start = active & ~active_prev.
- States:
  - IDLE: on start, latch a→mem_addr and d→mem_wdata. Set mem_we = ~wr, mem_io = ~iorq, mem_req = 1, wait_n = 0. Go to REQ.
  - REQ: hold all mem_* outputs. When mem_ack = 1: mem_req = 0, wait_n = 1, and for a read q ← mem_rdata. Go to DONE.
  - DONE: stay until active = 0, then go to IDLE.
- Each CPU cycle produces exactly one request, however long the strobe is held.
- Refresh cycles (rfsh low) never produce a request.
- Interrupt-acknowledge cycles (iorq & m1 low) never produce a request. q = 8'hFF while iorq & m1 are both low.
- Writes leave q unchanged.
- mem_ack outside REQ is ignored.
- Strobe released while in REQ (aborted cycle): keep waiting for mem_ack and apply the update normally. If active is already 0 when mem_ack arrives, go directly to IDLE.
- Reset values: q = 8'hFF, wait_n = 1, mem_req = 0, mem_we = 0, mem_io = 0, mem_addr = 16'h0000, mem_wdata = 8'h00, state = IDLE, active_prev = 0.
- Reset asserted mid-transaction returns everything to reset values immediately. An outstanding acknowledge is then dropped, because mem_ack outside REQ is ignored.

## Timing
- start is detected at clock edge n. At that same edge mem_req rises and wait_n falls; both are registered outputs.
- mem_ack is sampled high at edge m. At edge m, mem_req falls, wait_n rises and q updates. Read latency = (m − n) clocks.
- Minimum latency: mem_ack in the clock after mem_req rises gives one wait clock.
- Clock must run at least 4× the CPU clock-enable rate, so wait_n is low before the CPU samples WAIT in T2.
- Back-to-back cycles: a new start is accepted only after active has returned to 0 (through DONE).

## Configuration
- Z80_RESPONDER_IO_EN defined: I/O read/write cycles (iorq low, m1 high) are forwarded with mem_io = 1 and follow the same protocol.
- Not defined: no I/O requests are generated and mem_io stays 0. I/O reads return q = 8'hFF while iorq & ~rd; wait_n stays 1. I/O writes are discarded.

## Test plan
- Memory read at 16'h1234, ack 3 clocks after mem_req, mem_rdata = 8'hA5:
  - mem_req with mem_addr = 16'h1234, mem_we = 0, mem_io = 0.
  - wait_n low for exactly 3 clocks.
  - q = 8'hA5 at the ack edge; wait_n high.
- Write 8'h5A to 16'hC000 with wr held low for 10 clocks:
  - exactly one mem_req pulse train, with mem_we = 1 and mem_wdata = 8'h5A.
  - q unchanged.
- Refresh cycle (mreq low, rfsh low, rd high) at 16'h007F: mem_req stays 0, wait_n stays 1.
- I/O read of port 16'h00FE:
  - with macro: mem_io = 1, mem_addr = 16'h00FE.
  - without macro: no mem_req, q = 8'hFF, wait_n = 1.
- reset asserted while in REQ: mem_req = 0, wait_n = 1, q = 8'hFF immediately. A late mem_ack is ignored. The next read completes normally.
- rd released before mem_ack (aborted read): ack applied (q ← mem_rdata), block returns to IDLE, no second request issued.

Source files
------------

// File: rtl/z80_bus_responder.sv
// Z80 bus target: turns each qualifying CPU memory/IO cycle into one req/ack transaction and stretches it with wait_n.
// Optional feature: define Z80_RESPONDER_IO_EN to forward I/O cycles (otherwise only memory cycles are forwarded).
module z80_bus_responder (
  input  logic        clock,
  input  logic        reset,
  input  logic        mreq,
  input  logic        iorq,
  input  logic        rd,
  input  logic        wr,
  input  logic        m1,
  input  logic        rfsh,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  output logic [7:0]  q,
  output logic        wait_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_io,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

`ifdef Z80_RESPONDER_IO_EN
  localparam logic IO_OK = 1'b1;
`else
  localparam logic IO_OK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t     state;
  logic       strobe;
  logic       active;
  logic       active_prev;
  logic       start;
  logic       int_ack;
  logic       io_float;
  logic [7:0] q_reg;

  assign strobe   = ~rd | ~wr;
  assign active   = (~mreq & rfsh & strobe) | (IO_OK & ~iorq & m1 & strobe);
  assign start    = active & ~active_prev;
  assign int_ack  = ~iorq & ~m1;
  // Unforwarded I/O reads see a floating bus; interrupt acknowledge always reads 8'hFF.
  assign io_float = ~IO_OK & ~iorq & ~rd;
  assign q        = (int_ack | io_float) ? 8'hFF : q_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      active_prev <= 1'b0;
      q_reg       <= 8'hFF;
      wait_n      <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_io      <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_wdata   <= 8'h00;
    end else begin
      active_prev <= active;
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr  <= a;
            mem_wdata <= d;
            mem_we    <= ~wr;
            mem_io    <= IO_OK & ~iorq;
            mem_req   <= 1'b1;
            wait_n    <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          // An aborted cycle still completes; it just skips DONE.
          if (mem_ack) begin
            mem_req <= 1'b0;
            wait_n  <= 1'b1;
            if (!mem_we) q_reg <= mem_rdata;
            state   <= active ? DONE : IDLE;
          end
        end
        DONE: begin
          if (!active) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Randomized scoreboard bench for z80_bus_responder: expected requests/completions are queued by the driver and popped by a monitor.
module tb_z80_bus_responder;

`ifdef Z80_RESPONDER_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  localparam int K_MRD  = 0;
  localparam int K_MWR  = 1;
  localparam int K_RFSH = 2;
  localparam int K_IORD = 3;
  localparam int K_IOWR = 4;
  localparam int K_INTA = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic        mreq, iorq, rd, wr, m1, rfsh;
  logic [15:0] a;
  logic [7:0]  d;
  logic [7:0]  q;
  logic        wait_n;
  logic        mem_req, mem_we, mem_io;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  z80_bus_responder dut (
    .clock(clock), .reset(reset),
    .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .m1(m1), .rfsh(rfsh),
    .a(a), .d(d), .q(q), .wait_n(wait_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic        io;
    logic [7:0]  wdata;
  } req_t;

  typedef struct {
    int         lat;
    logic [7:0] qv;
  } cmp_t;

  req_t       req_q[$];
  cmp_t       cmp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cur_lat = 1;
  logic [7:0] cur_rdata = 8'h00;
  logic [7:0] model_q = 8'hFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_idle();
    mreq = 1'b1; iorq = 1'b1; rd = 1'b1; wr = 1'b1; m1 = 1'b1; rfsh = 1'b1;
  endtask

  // Memory side: acknowledge cur_lat clocks after mem_req rises.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clock);
      if (mem_req === 1'b1 && reset === 1'b0) begin
        int l;
        logic [7:0] r;
        l = cur_lat;
        r = cur_rdata;
        repeat (l - 1) @(negedge clock);
        mem_ack = 1'b1;
        mem_rdata = r;
        @(negedge clock);
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom);
      end
    end
  end

  // Monitor: pops expectations on mem_req rise and on wait_n release.
  initial begin
    req_t e;
    cmp_t c;
    logic pr;
    logic pw;
    int   wcnt;
    pr = 1'b0; pw = 1'b1; wcnt = 0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b0) begin
        pr = 1'b0; pw = 1'b1; wcnt = 0;
      end else begin
        if (mem_req && !pr) begin
          if (req_q.size() == 0) check("req_expected", 32'd0, 32'd1);
          else begin
            e = req_q.pop_front();
            check("req_addr", mem_addr, e.addr);
            check("req_we", mem_we, e.we);
            check("req_io", mem_io, e.io);
            check("req_wdata", mem_wdata, e.wdata);
            check("req_wait_low", wait_n, 1'b0);
          end
        end
        if (!wait_n) wcnt++;
        if (wait_n && !pw) begin
          if (cmp_q.size() == 0) check("completion_expected", 32'd0, 32'd1);
          else begin
            c = cmp_q.pop_front();
            check("wait_clocks", wcnt, c.lat);
            check("q_at_ack", q, c.qv);
            check("req_dropped", mem_req, 1'b0);
          end
          wcnt = 0;
        end
        pr = mem_req;
        pw = wait_n;
      end
    end
  end

  task automatic cpu_cycle(input int kind, input logic [15:0] addr, input logic [7:0] data,
                           input int hold, input int lat, input logic [7:0] rdata,
                           input bit abort, input bit fetch);
    bit is_rd;
    bit is_io;
    bit fwd;
    bit seen_low;
    int n;
    is_rd = (kind == K_MRD) || (kind == K_IORD);
    is_io = (kind == K_IORD) || (kind == K_IOWR);
    fwd   = (kind == K_MRD) || (kind == K_MWR) || (IO_EN && is_io);
    cur_lat = lat;
    cur_rdata = rdata;
    if (fwd) begin
      req_q.push_back('{addr, !is_rd, is_io, data});
      if (is_rd) model_q = rdata;
      cmp_q.push_back('{lat, model_q});
    end
    @(posedge clock); #1;
    a = addr;
    d = data;
    case (kind)
      K_MRD:   begin mreq = 1'b0; rd = 1'b0; m1 = !fetch; end
      K_MWR:   begin mreq = 1'b0; wr = 1'b0; end
      K_RFSH:  begin mreq = 1'b0; rfsh = 1'b0; end
      K_IORD:  begin iorq = 1'b0; rd = 1'b0; end
      K_IOWR:  begin iorq = 1'b0; wr = 1'b0; end
      default: begin iorq = 1'b0; m1 = 1'b0; end
    endcase
    n = 0;
    seen_low = 1'b0;
    forever begin
      @(negedge clock);
      n++;
      if (!wait_n) seen_low = 1'b1;
      if (!fwd && n == 2) begin
        check("noreq_mem_req", mem_req, 1'b0);
        check("noreq_wait_n", wait_n, 1'b1);
        if (kind == K_INTA || kind == K_IORD) check("q_float", q, 8'hFF);
      end
      if (abort) begin
        if (n >= 2) break;
      end else if (!fwd) begin
        if (n >= hold) break;
      end else if (n >= hold && seen_low && wait_n) break;
      if (n > 200) begin
        check("cycle_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clock); #1;
    bus_idle();
    n = 0;
    while (wait_n !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("release_timeout", 32'd0, 32'd1);
    @(negedge clock);
    check("q_after_cycle", q, model_q);
    repeat (2) @(posedge clock);
  endtask

  task automatic reset_in_req();
    logic [7:0] dd;
    bit ok;
    dd = 8'($urandom);
    cur_lat = 8;
    cur_rdata = 8'h3C;
    req_q.push_back('{16'h2000, 1'b0, 1'b0, dd});
    @(posedge clock); #1;
    a = 16'h2000; d = dd; mreq = 1'b0; rd = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_reset_req", mem_req, 1'b1);
    @(posedge clock); #1;
    reset = 1'b1;
    bus_idle();
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_wait_n", wait_n, 1'b1);
    check("rst_q", q, 8'hFF);
    model_q = 8'hFF;
    @(posedge clock); #1;
    reset = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (mem_req !== 1'b0 || wait_n !== 1'b1) ok = 1'b0;
    end
    check("late_ack_ignored", ok, 1'b1);
    check("late_ack_q", q, 8'hFF);
    repeat (2) @(posedge clock);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    a = 16'h0000;
    d = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_q", q, 8'hFF);
    check("reset_wait_n", wait_n, 1'b1);
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_mem_we", mem_we, 1'b0);
    check("reset_mem_io", mem_io, 1'b0);
    check("reset_mem_addr", mem_addr, 16'h0000);
    check("reset_mem_wdata", mem_wdata, 8'h00);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    cpu_cycle(K_MRD,  16'h1234, 8'h11, 1,  3, 8'hA5, 1'b0, 1'b0);
    cpu_cycle(K_MWR,  16'hC000, 8'h5A, 10, 2, 8'h77, 1'b0, 1'b0);
    cpu_cycle(K_RFSH, 16'h007F, 8'h00, 3,  1, 8'h22, 1'b0, 1'b0);
    cpu_cycle(K_IORD, 16'h00FE, 8'h00, 2,  2, 8'h6B, 1'b0, 1'b0);
    cpu_cycle(K_IOWR, 16'h00FE, 8'h81, 3,  2, 8'h44, 1'b0, 1'b0);
    cpu_cycle(K_INTA, 16'h0038, 8'h00, 3,  1, 8'h55, 1'b0, 1'b0);
    cpu_cycle(K_MRD,  16'h4000, 8'h00, 1,  5, 8'hC3, 1'b1, 1'b0);
    cpu_cycle(K_MRD,  16'h0000, 8'h00, 1,  1, 8'h3E, 1'b0, 1'b1);
    reset_in_req();
    cpu_cycle(K_MRD,  16'h8001, 8'h00, 2,  2, 8'h9D, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int kind;
      int lat;
      bit abort;
      kind  = $urandom_range(0, 5);
      lat   = $urandom_range(1, 6);
      abort = (kind == K_MRD) && (lat >= 3) && ($urandom_range(0, 3) == 0);
      cpu_cycle(kind, 16'($urandom), 8'($urandom), $urandom_range(2, 12), lat,
                8'($urandom), abort, 1'($urandom));
    end

    repeat (5) @(posedge clock);
    check("req_queue_drained", req_q.size(), 32'd0);
    check("cmp_queue_drained", cmp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
